// File: rtl/mon_prod_ctrl.sv
// mon_prod_ctrl: loads A/B/M words, starts the Montgomery core, waits for P and streams it out
module mon_prod_ctrl #(
    parameter int bitLen    = 64,
    parameter int N         = 32,
    parameter int WORDS     = bitLen / N,
    parameter int wcntWidth = 2,
    parameter int TIMEOUT   = 4096,
    parameter int toWidth   = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      in_word,
    input  logic              in_valid,
    output logic [bitLen-1:0] mp_A,
    output logic [bitLen-1:0] mp_B,
    output logic [bitLen-1:0] mp_M,
    output logic              mp_start,
    input  logic              mp_stop,
    input  logic [bitLen-1:0] mp_P,
    output logic [N-1:0]      out_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              overrun,
    output logic              timeout,
    output logic [2:0]        state
);
    localparam logic [wcntWidth-1:0] LAST_WORD = wcntWidth'(WORDS - 1);
    localparam logic [toWidth-1:0]   LAST_WAIT = toWidth'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        LOAD_M = 3'd2,
        START  = 3'd3,
        WAIT   = 3'd4,
        SEND   = 3'd5
    } state_t;

    state_t               st, st_nx;
    logic [wcntWidth-1:0] wcnt;
    logic [toWidth-1:0]   tcnt;
    logic [bitLen-1:0]    p_q;
    logic                 loading, last_word, stop_ok, to_hit, xfer;

    assign loading   = (st == LOAD_A) || (st == LOAD_B) || (st == LOAD_M);
    assign last_word = wcnt == LAST_WORD;
    // tcnt==0 marks the guard cycle, where a stale mp_stop from the last run is ignored
    assign stop_ok   = (st == WAIT) && (tcnt != '0) && mp_stop;
    assign to_hit    = (st == WAIT) && !stop_ok && (tcnt == LAST_WAIT);
    assign xfer      = (st == SEND) && out_ready;
    assign mp_start  = st == START;
    assign out_valid = st == SEND;
    assign out_word  = out_valid ? p_q[N*int'(wcnt) +: N] : '0;
    assign busy      = !((st == LOAD_A) && (wcnt == '0));
    assign state     = st;

    // Next-state selection
    always_comb begin
        st_nx = st;
        case (st)
            LOAD_A:  st_nx = (in_valid && last_word) ? LOAD_B : LOAD_A;
            LOAD_B:  st_nx = (in_valid && last_word) ? LOAD_M : LOAD_B;
            LOAD_M:  st_nx = (in_valid && last_word) ? START : LOAD_M;
            START:   st_nx = WAIT;
            WAIT:    st_nx = stop_ok ? SEND : (to_hit ? LOAD_A : WAIT);
            SEND:    st_nx = (xfer && last_word) ? LOAD_A : SEND;
            default: st_nx = LOAD_A;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= LOAD_A;
        else        st <= st_nx;
    end

    // Word counter shared by loading and sending; wait counter runs only in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= '0;
            tcnt <= '0;
        end else begin
            if ((loading && in_valid) || xfer) wcnt <= last_word ? '0 : wcnt + 1'b1;
            else if (stop_ok)                  wcnt <= '0;
            tcnt <= (st == WAIT) ? tcnt + 1'b1 : '0;
        end
    end

    // Operand word capture (first word is least significant) and one-shot result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mp_A <= '0;
            mp_B <= '0;
            mp_M <= '0;
            p_q  <= '0;
        end else begin
            if (in_valid && st == LOAD_A) mp_A[N*int'(wcnt) +: N] <= in_word;
            if (in_valid && st == LOAD_B) mp_B[N*int'(wcnt) +: N] <= in_word;
            if (in_valid && st == LOAD_M) mp_M[N*int'(wcnt) +: N] <= in_word;
            if (stop_ok) p_q <= mp_P;
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (in_valid && !loading) overrun <= 1'b1;
            if (to_hit)               timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mon_prod_ctrl.sv
// tb_mon_prod_ctrl: randomized scenario tests of mon_prod_ctrl against a word-level model
module tb_mon_prod_ctrl;
    localparam int BL = 64;
    localparam int NW = 32;
    localparam int W  = BL / NW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NW-1:0] in_word = '0;
    logic          in_valid = 1'b0;
    logic [BL-1:0] mp_A, mp_B, mp_M;
    logic          mp_start;
    logic          mp_stop = 1'b0;
    logic [BL-1:0] mp_P = '0;
    logic [NW-1:0] out_word;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy, overrun, timeout;
    logic [2:0]    state;

    int            checks = 0;
    int            errors = 0;
    logic [NW-1:0] rx_q[$];
    bit            exp_ovr = 1'b0;
    bit            exp_to = 1'b0;

    mon_prod_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid),
        .mp_A(mp_A), .mp_B(mp_B), .mp_M(mp_M), .mp_start(mp_start),
        .mp_stop(mp_stop), .mp_P(mp_P), .out_word(out_word), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .overrun(overrun), .timeout(timeout),
        .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [BL-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Stimulus driver: sends A, B, M as word streams, LS word first, optional idle gaps
    task automatic load_op(input logic [BL-1:0] a, input logic [BL-1:0] b,
                           input logic [BL-1:0] m, input bit gaps);
        logic [BL-1:0] ops[3];
        ops = '{a, b, m};
        for (int i = 0; i < 3 * W; i++) begin
            if (gaps && i > 0) repeat ($urandom_range(0, 3)) @(negedge clk);
            in_valid = 1'b1;
            in_word  = NW'(ops[i / W] >> (NW * (i % W)));
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Stimulus driver: plays the transmitter with random readiness and collects accepted words
    task automatic recv(input int ready_pct);
        rx_q.delete();
        for (int c = 0; c < 1000 && rx_q.size() < W; c++) begin
            out_ready = ($urandom_range(1, 100) <= ready_pct);
            if (out_valid && out_ready) rx_q.push_back(out_word);
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({mp_A, mp_B, mp_M} !== '0 || mp_start !== 1'b0 || out_word !== '0 || out_valid !== 1'b0 ||
            overrun !== 1'b0 || timeout !== 1'b0 || state !== 3'd0 || busy !== 1'b0)
            begin errors++; $display("FAIL reset_values: A=%h start=%b ow=%h ov=%b orun=%b to=%b st=%0d busy=%b, required all 0",
                                     mp_A, mp_start, out_word, out_valid, overrun, timeout, state, busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (mp_start !== 1'b0 || state !== 3'd0)
            begin errors++; $display("FAIL reset_release: start=%b st=%0d, required 0 0", mp_start, state); end
    endtask

    task automatic test_basic();
        logic [BL-1:0] p = 64'h1122334455667788;
        load_op(64'd5, 64'd7, 64'd13, 1'b0);
        checks++;
        if (mp_start !== 1'b1 || state !== 3'd3 || busy !== 1'b1)
            begin errors++; $display("FAIL basic_start: start=%b st=%0d busy=%b, required 1 3 1", mp_start, state, busy); end
        checks++;
        if (mp_A !== 64'd5 || mp_B !== 64'd7 || mp_M !== 64'd13)
            begin errors++; $display("FAIL basic_operands: A=%h B=%h M=%h, required 5 7 d", mp_A, mp_B, mp_M); end
        mp_stop = 1'b0;
        @(negedge clk);
        checks++;
        if (mp_start !== 1'b0 || state !== 3'd4)
            begin errors++; $display("FAIL basic_single_pulse: start=%b st=%0d, required 0 4", mp_start, state); end
        repeat (9) @(negedge clk);
        mp_P = p;
        mp_stop = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_word !== 32'h55667788)
            begin errors++; $display("FAIL basic_first_word: valid=%b word=%h, required 1 55667788", out_valid, out_word); end
        recv(100);
        checks++;
        if (rx_q.size() != W || rx_q[0] !== 32'h55667788 || rx_q[1] !== 32'h11223344)
            begin errors++; $display("FAIL basic_words: n=%0d w0=%h w1=%h, required 2 55667788 11223344", rx_q.size(), rx_q[0], rx_q[1]); end
        checks++;
        if (state !== 3'd0 || out_valid !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL basic_idle: st=%0d valid=%b busy=%b, required 0 0 0", state, out_valid, busy); end
    endtask

    task automatic test_stale_backpressure();
        logic [BL-1:0] p = rnd64();
        int n = 0;
        int bad = 0;
        load_op(rnd64(), rnd64(), rnd64(), 1'b1);
        mp_P = p;
        checks++;
        if (mp_start !== 1'b1 || mp_stop !== 1'b1)
            begin errors++; $display("FAIL stale_start: start=%b stop=%b, required 1 1", mp_start, mp_stop); end
        while (out_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (n != 3)
            begin errors++; $display("FAIL stale_guard_latency: cycles=%0d, required 3", n); end
        out_ready = 1'b0;
        repeat (20) begin
            if (out_valid !== 1'b1 || out_word !== p[31:0]) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0)
            begin errors++; $display("FAIL backpressure_hold: bad_cycles=%0d word=%h, required 0 %h", bad, out_word, p[31:0]); end
        recv(50);
        checks++;
        if (rx_q.size() != W || rx_q[0] !== NW'(p) || rx_q[1] !== NW'(p >> NW))
            begin errors++; $display("FAIL backpressure_words: n=%0d w0=%h w1=%h, required 2 %h %h",
                                     rx_q.size(), rx_q[0], rx_q[1], NW'(p), NW'(p >> NW)); end
    endtask

    task automatic test_overrun();
        logic [BL-1:0] a = rnd64(), b = rnd64(), m = rnd64(), p = rnd64();
        checks++;
        if (overrun !== 1'b0)
            begin errors++; $display("FAIL overrun_clear: overrun=%b, required 0", overrun); end
        load_op(a, b, m, 1'b0);
        mp_stop = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_word  = 32'hDEADBEEF;
        @(negedge clk);
        in_valid = 1'b0;
        exp_ovr  = 1'b1;
        checks++;
        if (overrun !== 1'b1)
            begin errors++; $display("FAIL overrun_set: overrun=%b, required 1", overrun); end
        checks++;
        if (mp_A !== a || mp_B !== b || mp_M !== m)
            begin errors++; $display("FAIL overrun_operands: A=%h B=%h M=%h, required %h %h %h", mp_A, mp_B, mp_M, a, b, m); end
        repeat (4) @(negedge clk);
        mp_P = p;
        mp_stop = 1'b1;
        @(negedge clk);
        recv(70);
        checks++;
        if (rx_q.size() != W || rx_q[0] !== NW'(p) || rx_q[1] !== NW'(p >> NW) || overrun !== 1'b1)
            begin errors++; $display("FAIL overrun_result: n=%0d w0=%h w1=%h orun=%b, required 2 %h %h 1",
                                     rx_q.size(), rx_q[0], rx_q[1], overrun, NW'(p), NW'(p >> NW)); end
    endtask

    task automatic test_timeout();
        int  n = 0;
        bit  saw_valid = 1'b0;
        load_op(rnd64(), rnd64(), rnd64(), 1'b0);
        mp_stop = 1'b0;
        mp_P = rnd64();
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) saw_valid = 1'b1;
            if (state === 3'd4) n++;
            else break;
        end
        exp_to = 1'b1;
        checks++;
        if (n != 4096)
            begin errors++; $display("FAIL timeout_cycles: wait_cycles=%0d, required 4096", n); end
        checks++;
        if (timeout !== 1'b1 || state !== 3'd0 || saw_valid)
            begin errors++; $display("FAIL timeout_flags: to=%b st=%0d saw_valid=%b, required 1 0 0", timeout, state, saw_valid); end
    endtask

    task automatic test_reset_mid();
        load_op(rnd64(), rnd64(), rnd64(), 1'b0);
        mp_stop = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_ovr = 1'b0;
        exp_to  = 1'b0;
        checks++;
        if ({mp_A, mp_B, mp_M} !== '0 || mp_start !== 1'b0 || out_word !== '0 || out_valid !== 1'b0 ||
            overrun !== 1'b0 || timeout !== 1'b0 || state !== 3'd0 || busy !== 1'b0)
            begin errors++; $display("FAIL reset_mid_async: A=%h start=%b ov=%b orun=%b to=%b st=%0d busy=%b, required all 0",
                                     mp_A, mp_start, out_valid, overrun, timeout, state, busy); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (mp_start !== 1'b0 || state !== 3'd0 || busy !== 1'b0)
            begin errors++; $display("FAIL reset_mid_release: start=%b st=%0d busy=%b, required 0 0 0", mp_start, state, busy); end
    endtask

    task automatic test_random(input int n_ops);
        for (int k = 0; k < n_ops; k++) begin
            logic [BL-1:0] a = rnd64(), b = rnd64(), m = rnd64(), p = rnd64();
            int delay = $urandom_range(2, 30);
            int pct   = $urandom_range(30, 100);
            load_op(a, b, m, 1'b1);
            checks++;
            if (mp_start !== 1'b1 || mp_A !== a || mp_B !== b || mp_M !== m)
                begin errors++; $display("FAIL rand_load[%0d]: start=%b A=%h B=%h M=%h, required 1 %h %h %h",
                                         k, mp_start, mp_A, mp_B, mp_M, a, b, m); end
            mp_stop = 1'b0;
            repeat (delay) @(negedge clk);
            mp_P = p;
            mp_stop = 1'b1;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1)
                begin errors++; $display("FAIL rand_latency[%0d]: valid=%b, required 1", k, out_valid); end
            mp_P = rnd64();
            recv(pct);
            checks++;
            if (rx_q.size() != W || rx_q[0] !== NW'(p) || rx_q[1] !== NW'(p >> NW))
                begin errors++; $display("FAIL rand_words[%0d]: n=%0d w0=%h w1=%h, required 2 %h %h",
                                         k, rx_q.size(), rx_q[0], rx_q[1], NW'(p), NW'(p >> NW)); end
            checks++;
            if (state !== 3'd0 || overrun !== exp_ovr || timeout !== exp_to)
                begin errors++; $display("FAIL rand_end[%0d]: st=%0d orun=%b to=%b, required 0 %b %b",
                                         k, state, overrun, timeout, exp_ovr, exp_to); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stale_backpressure();
        test_overrun();
        test_timeout();
        test_random(3);
        test_reset_mid();
        test_random(6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mon_prod_ctrl.md
Name: mon_prod_ctrl

Overview:
Sequencer between the UART word path and the Montgomery-product core. Collects operands A, B, M as N-bit words from the serial-to-parallel assembler and issues a one-cycle start to the mon_prod core. It then waits for completion, captures P and streams it back as N-bit words to the parallel-to-serial transmitter. Also provides overrun and timeout flags and a state code for the board LEDs.

Parameters:
bitLen, 64, operand/result width in bits; must be an integer multiple of N
N, 32, word width of the inbound/outbound word bus
WORDS, bitLen/N, words per operand (default 2)
wcntWidth, 2, counter width; must satisfy 2^wcntWidth > WORDS
TIMEOUT, 4096, maximum cycles to wait for mp_stop before aborting
toWidth, 13, timeout counter width; must satisfy 2^toWidth > TIMEOUT

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_word  in  N  inbound word from serial_to_parallel
in_valid  in  1  one-cycle strobe, in_word valid
mp_A  out  bitLen  operand A to mon_prod
mp_B  out  bitLen  operand B to mon_prod
mp_M  out  bitLen  modulus to mon_prod
mp_start  out  1  one-cycle start pulse to mon_prod
mp_stop  in  1  mon_prod done level, held until next start
mp_P  in  bitLen  mon_prod result
out_word  out  N  outbound word to parallel_to_serial
out_valid  out  1  outbound word valid, held until accepted
out_ready  in  1  transmitter can accept; transfer when out_valid&&out_ready
busy  out  1  high in any state except LOAD_A with word count 0
overrun  out  1  sticky: in_valid seen while not loading
timeout  out  1  sticky: mp_stop not seen within TIMEOUT cycles
state  out  3  current state encoding (LED use)

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: mp_A/B/M=0, mp_start=0, out_word=0, out_valid=0, overrun=0, timeout=0.
  - Internals: P register=0, word counter=0, timeout counter=0, state=LOAD_A (code 0).
- State encodings: LOAD_A=0, LOAD_B=1, LOAD_M=2, START=3, WAIT=4, SEND=5.
- LOAD_A/LOAD_B/LOAD_M:
  - Each in_valid writes in_word into slice [N*k +: N] of the current operand, where k = word counter. The first word received is least significant.
  - On the WORDS-th word, the counter clears and the state advances: A->B->M->START.
  - Operand registers hold their values until overwritten by the next load.
- START: mp_start=1 for exactly this one cycle; the timeout counter clears; next state is WAIT.
- WAIT:
  - The first WAIT cycle is a guard cycle: mp_stop is ignored, because it may still be high from the previous operation.
  - From the second WAIT cycle on, the first cycle with mp_stop=1 latches mp_P into the P register; next state is SEND, word counter=0.
  - The timeout counter increments every WAIT cycle. If it reaches TIMEOUT without mp_stop, set timeout=1, return to LOAD_A, and send no result.
- SEND:
  - out_word = P[N*k +: N], out_valid=1.
  - On each out_valid&&out_ready cycle, k increments. After the last word is accepted: out_valid=0 the next cycle, counter=0, state LOAD_A.
  - Latency from the final M word to mp_start is 1 cycle. Latency from the qualifying mp_stop to the first out_valid is 1 cycle.
- in_valid in START, WAIT or SEND: the word is dropped and overrun is set. Overrun and timeout clear only on reset.
- in_valid and out_ready in the same cycle are independent. Because SEND never loads, overrun is the only effect.
- Reset mid-operation aborts immediately. mp_start must not glitch high on reset release.
- P is captured once per operation. Later changes on mp_P are ignored until the next WAIT.

Test Plan:
1. Reset mid-operation: assert rst_n=0 during WAIT -> all outputs 0 asynchronously, state=0. After release, a new 6-word load starts cleanly.
2. Basic operation: send words 0x00000005, 0x0, 0x00000007, 0x0, 0x0000000D, 0x0 -> mp_A=5, mp_B=7, mp_M=13, mp_start pulses once 1 cycle after the 6th word. Model mp_stop 10 cycles later with mp_P=64'h1122334455667788 -> out_word 0x55667788 then 0x11223344, then state=0.
3. Backpressure and stale stop:
   - Hold out_ready=0 for 20 cycles in SEND -> out_valid stays 1 and out_word stays 0x55667788; no word is skipped.
   - Keep mp_stop high from the previous operation through the next START -> the guard cycle ignores it and P is captured on the 2nd WAIT cycle.
4. Overrun: pulse in_valid with 0xDEADBEEF during WAIT -> overrun=1 (sticky), operands unchanged, result still sent correctly.
5. Timeout: never assert mp_stop -> after 4096 WAIT cycles timeout=1 and state=0, with no out_valid. A following normal operation still completes.
